// File: rtl/regfile_scoreboard_pkg.sv
// ============================================================================
// regfile_scoreboard_pkg : shared defaults and constants for the register file
// Revision: 1.0
// ============================================================================
`default_nettype none

package regfile_scoreboard_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int NRD_DEFAULT  = 2;
    localparam int REG_ZERO     = 0;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard_sb_popcount.sv
// ============================================================================
// sb_popcount : population count of a pending-bit vector
// Revision: 1.0
// ============================================================================
`default_nettype none

module sb_popcount #(
    parameter int N = 32,
    parameter int W = 6
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(bits[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard : register file with pending-write scoreboard, RAW/WAW
//                      issue stall and same-cycle write-back bypass
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int  XLEN = XLEN_DEFAULT,
    parameter int  NREG = NREG_DEFAULT,
    parameter int  NRD  = NRD_DEFAULT,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    output logic                iss_ready,
    input  logic [NRD*AW-1:0]   iss_rs,
    input  logic [AW-1:0]       iss_rd,
    input  logic                iss_wen,
    output logic                rd_valid,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [AW:0]         pend_cnt,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    logic [XLEN-1:0]     r_regs [NREG];
    logic [NREG-1:0]     r_pending;
    logic [NREG-1:0]     w_pending_nxt;
    logic [AW:0]         w_pend_cnt_nxt;
    logic [NRD-1:0]      w_src_hazard;
    logic [NRD*XLEN-1:0] w_operands;
    logic                w_dst_hazard;
    logic                w_accept;
    logic                w_wb_write;

    assign w_wb_write = wb_valid && (wb_addr != AW'(REG_ZERO));

    // Register 0 is never pending, so it can never raise a source hazard.
    generate
        for (genvar k = 0; k < NRD; k++) begin : g_port
            logic [AW-1:0] w_rs;
            logic          w_wb_hit;

            assign w_rs            = iss_rs[k*AW +: AW];
            assign w_wb_hit        = wb_valid && (wb_addr == w_rs) && (w_rs != AW'(REG_ZERO));
            assign w_src_hazard[k] = r_pending[w_rs] && !w_wb_hit;
            assign w_operands[k*XLEN +: XLEN] = w_wb_hit ? wb_data : r_regs[w_rs];
        end
    endgenerate

    assign w_dst_hazard = iss_wen && (iss_rd != AW'(REG_ZERO)) && r_pending[iss_rd]
                          && !(wb_valid && (wb_addr == iss_rd));
    assign iss_ready    = !flush && !(|w_src_hazard) && !w_dst_hazard;
    assign w_accept     = iss_valid && iss_ready;

    // Clear from write-back first, then set from issue: a new producer owns the register.
    always_comb begin
        w_pending_nxt = r_pending;
        if (flush) begin
            w_pending_nxt = '0;
        end else begin
            if (w_wb_write) begin
                w_pending_nxt[wb_addr] = 1'b0;
            end
            if (w_accept && iss_wen && (iss_rd != AW'(REG_ZERO))) begin
                w_pending_nxt[iss_rd] = 1'b1;
            end
        end
    end

    sb_popcount #(
        .N (NREG),
        .W (AW + 1)
    ) u_popcount (
        .bits  (w_pending_nxt),
        .count (w_pend_cnt_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_write) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            pend_cnt  <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            pend_cnt  <= w_pend_cnt_nxt;
            rd_valid  <= w_accept;
            if (w_accept) begin
                rd_data <= w_operands;
            end
        end
    end

    assign dbg_data = r_regs[dbg_addr];

endmodule

`default_nettype wire
